scoreboard_hazard_unit: RTL and testbench
=========================================

# scoreboard_hazard_unit

Parametrised successor to the pipelined core's decode-stage hazard logic. A per-register countdown scoreboard replaces fixed load-use/branch comparisons, so variable-latency producers (load, multiply, divide) stall dependants for exactly the required cycles. Sits beside the D stage and drives fetch/decode stall, E-stage bubble, mispredict flush and PC-correction. Also detects WAW ordering hazards and counts stall cycles.

## Interface
- NUM_REGS, 32: architectural registers; register 0 is never tracked.
- REG_W, 5: register index width, $clog2(NUM_REGS).
- MAX_LAT, 8: largest producer latency; larger requests saturate to MAX_LAT.
- LAT_W, 4: counter width, $clog2(MAX_LAT+1).
- CNT_W, 32: stall performance counter width.
- clk  input  1  core clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- validD  input  1  D-stage holds an instruction.
- killD  input  1  D-stage instruction is wrong-path; treat as invalid.
- rsD, rtD  input  REG_W  source registers.
- useRsD, useRtD  input  1  source actually read.
- regWriteD  input  1  instruction writes writeRegisterD.
- writeRegisterD  input  REG_W  destination.
- latencyD  input  LAT_W  cycles until result is forwardable to an E-stage consumer (0 = ALU-forwardable now).
- branchD, takenBranchD, predictionD  input  1  branch resolved in D, actual outcome, predicted outcome.
- Stall  output  1  hold F and D.
- bubbleE  output  1  insert NOP into E (equals Stall).
- issueD  output  1  D instruction advances this cycle.
- Flush  output  1  mispredict; squash F.
- CPCSignal  output  1  select corrected PC / hold PC.
- busyMask  output  NUM_REGS  bit r set when cnt[r] != 0.
- stallCount  output  CNT_W  saturating count of stalled cycles.

## Operation
- State: cnt[1..NUM_REGS-1] (LAT_W each), lastValid, lastDest (instruction currently in E), stallCount.
- live = validD & ~killD. Sources checked only if use bit set and index != 0.
- RAW stall: live & src used & cnt[src] != 0.
- Branch stall: live & branchD & src used & (cnt[src] != 0 | (lastValid & lastDest == src)); branch operands need one extra cycle.
- WAW stall: live & regWriteD & writeRegisterD != 0 & cnt[writeRegisterD] > min(latencyD, MAX_LAT).
- Stall = OR of the above; bubbleE = Stall; issueD = live & ~Stall.
- Flush = issueD & branchD & (takenBranchD ^ predictionD).
- CPCSignal = Flush | Stall.
- Every cycle each nonzero cnt decrements by 1.
- On issueD & regWriteD & dest != 0: cnt[dest] <= min(latencyD, MAX_LAT), overriding decrement.
- lastValid <= issueD & regWriteD & dest != 0; lastDest <= writeRegisterD.
- stallCount increments when Stall, saturates at all-ones.
- killD or ~validD: no stall, no issue, no state write except decrement.

## Timing
- Stall, bubbleE, issueD, Flush, CPCSignal combinational from state and same-cycle inputs; state updates on rising clk.
- Reset (async, rst low): all cnt = 0, lastValid = 0, lastDest = 0, stallCount = 0; hence busyMask = 0 and Stall = Flush = CPCSignal = 0 with validD low. Reset mid-countdown clears all pending entries immediately.
- Producer with latencyD = L issued at cycle t: dependent ALU consumer stalls cycles t+1..t+L, issues t+L+1. With L = 0 no stall; branch consumer stalls cycle t+1 only.
- Self-dependency (dest == src) checks the old cnt, not the new one.
- Flush requires issue: a stalled mispredicting branch flushes only in the cycle it issues.

## Structure
- hazard_pkg: default NUM_REGS, REG_W, MAX_LAT, LAT_W, CNT_W, and the latency-class constants (LAT_ALU = 0, LAT_LOAD = 1, LAT_MUL, LAT_DIV).
- One sub-module, sb_reg_counter: single saturating-load, decrement-to-zero LAT_W counter with load enable, load value and busy output; instantiated NUM_REGS-1 times via generate.

## Test plan
- Reset: rst low mid-countdown with cnt[5] = 3 -> busyMask = 0, Stall = 0, stallCount = 0 immediately.
- Load-use: issue load to r8 latencyD = 1, next cycle add using rsD = 8 -> Stall = 1 for one cycle, issueD on second cycle, stallCount = 1.
- Divide: issue div to r9 latencyD = 6, dependent on r9 waits -> exactly 6 stall cycles; independent on r10 issues with no stall.
- Branch: ALU op to r3 latencyD = 0, then beq reading r3 -> one stall cycle; mispredicted (taken = 1, prediction = 0) on issue -> Flush = 1, CPCSignal = 1.
- WAW: div to r4 latencyD = 5, next cycle ALU op to r4 latencyD = 0 -> stalls until cnt[4] = 0; same with killD = 1 -> no stall.
- Register 0 and saturation: writes to r0 never set busyMask; latencyD = 15 with MAX_LAT = 8 -> busy exactly 8 cycles.

Source files
------------

// File: rtl/scoreboard_hazard_unit_pkg.sv
// scoreboard_hazard_unit_pkg: default sizing and producer latency classes for the scoreboard hazard unit.
//   NUM_REGS/REG_W : architectural register count and index width
//   MAX_LAT/LAT_W  : largest tracked producer latency and countdown width
//   CNT_W          : stall performance counter width
//   LAT_*          : cycles until a producer class result is forwardable to E
package scoreboard_hazard_unit_pkg;
    localparam int NUM_REGS = 32;
    localparam int REG_W    = $clog2(NUM_REGS);
    localparam int MAX_LAT  = 8;
    localparam int LAT_W    = $clog2(MAX_LAT + 1);
    localparam int CNT_W    = 32;
    localparam int LAT_ALU  = 0;
    localparam int LAT_LOAD = 1;
    localparam int LAT_MUL  = 3;
    localparam int LAT_DIV  = 6;
endpackage

// File: rtl/scoreboard_hazard_unit_if.sv
// scoreboard_hazard_unit_if: D-stage request and hazard response bundle.
//   master : decode stage, drives the instruction fields and samples the hazard controls
//   slave  : hazard unit, samples the instruction fields and drives stall/flush/PC-correction
interface scoreboard_hazard_unit_if
    import scoreboard_hazard_unit_pkg::*;
#(
    parameter int NUM_REGS = scoreboard_hazard_unit_pkg::NUM_REGS,
    parameter int REG_W    = scoreboard_hazard_unit_pkg::REG_W,
    parameter int LAT_W    = scoreboard_hazard_unit_pkg::LAT_W,
    parameter int CNT_W    = scoreboard_hazard_unit_pkg::CNT_W
) ();
    logic                validD;
    logic                killD;
    logic [REG_W-1:0]    rsD;
    logic [REG_W-1:0]    rtD;
    logic                useRsD;
    logic                useRtD;
    logic                regWriteD;
    logic [REG_W-1:0]    writeRegisterD;
    logic [LAT_W-1:0]    latencyD;
    logic                branchD;
    logic                takenBranchD;
    logic                predictionD;
    logic                Stall;
    logic                bubbleE;
    logic                issueD;
    logic                Flush;
    logic                CPCSignal;
    logic [NUM_REGS-1:0] busyMask;
    logic [CNT_W-1:0]    stallCount;

    modport master (
        output validD, killD, rsD, rtD, useRsD, useRtD, regWriteD, writeRegisterD,
               latencyD, branchD, takenBranchD, predictionD,
        input  Stall, bubbleE, issueD, Flush, CPCSignal, busyMask, stallCount
    );

    modport slave (
        input  validD, killD, rsD, rtD, useRsD, useRtD, regWriteD, writeRegisterD,
               latencyD, branchD, takenBranchD, predictionD,
        output Stall, bubbleE, issueD, Flush, CPCSignal, busyMask, stallCount
    );
endinterface

// File: rtl/scoreboard_hazard_unit_sb_reg_counter.sv
// sb_reg_counter: per-register countdown; loads a latency clamped to MAX_LAT, otherwise decrements to zero.
//   clk, rst : core clock, asynchronous active-low reset
//   load     : start a new countdown (wins over the decrement)
//   loadVal  : requested latency
//   count    : cycles remaining until the result is forwardable
//   busy     : count is nonzero
module sb_reg_counter
    import scoreboard_hazard_unit_pkg::*;
#(
    parameter int MAX_LAT = scoreboard_hazard_unit_pkg::MAX_LAT,
    parameter int LAT_W   = scoreboard_hazard_unit_pkg::LAT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [LAT_W-1:0] loadVal,
    output logic [LAT_W-1:0] count,
    output logic             busy
);
    assign busy = count != '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            count <= '0;
        else if (load)
            count <= (loadVal > LAT_W'(MAX_LAT)) ? LAT_W'(MAX_LAT) : loadVal;
        else if (busy)
            count <= count - 1'b1;
    end
endmodule

// File: rtl/scoreboard_hazard_unit.sv
// scoreboard_hazard_unit: countdown-scoreboard RAW/branch/WAW hazard detection beside the D stage.
//   clk, rst : core clock, asynchronous active-low reset
//   hz       : slave side of the D-stage bundle; instruction fields in, Stall/bubbleE/issueD/
//              Flush/CPCSignal, per-register busyMask and saturating stallCount out
module scoreboard_hazard_unit
    import scoreboard_hazard_unit_pkg::*;
#(
    parameter int NUM_REGS = scoreboard_hazard_unit_pkg::NUM_REGS,
    parameter int REG_W    = scoreboard_hazard_unit_pkg::REG_W,
    parameter int MAX_LAT  = scoreboard_hazard_unit_pkg::MAX_LAT,
    parameter int LAT_W    = scoreboard_hazard_unit_pkg::LAT_W,
    parameter int CNT_W    = scoreboard_hazard_unit_pkg::CNT_W
) (
    input logic clk,
    input logic rst,
    scoreboard_hazard_unit_if.slave hz
);
    logic [LAT_W-1:0]    cnt [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic                lastValid;
    logic [REG_W-1:0]    lastDest;
    logic [CNT_W-1:0]    stallCount;
    logic                live, rsChk, rtChk, rawStall, brStall, wawStall, stall, issue, destOk;
    logic [LAT_W-1:0]    satLat;

    // r0 is hard-wired, so it never holds a pending result
    assign cnt[0]  = '0;
    assign busy[0] = 1'b0;

    genvar r;
    for (r = 1; r < NUM_REGS; r++) begin : gCnt
        sb_reg_counter #(.MAX_LAT(MAX_LAT), .LAT_W(LAT_W)) uCnt (
            .clk     (clk),
            .rst     (rst),
            .load    (issue && hz.regWriteD && hz.writeRegisterD == REG_W'(r)),
            .loadVal (hz.latencyD),
            .count   (cnt[r]),
            .busy    (busy[r])
        );
    end

    assign live   = hz.validD && !hz.killD;
    assign rsChk  = hz.useRsD && hz.rsD != '0;
    assign rtChk  = hz.useRtD && hz.rtD != '0;
    assign destOk = hz.regWriteD && hz.writeRegisterD != '0;
    assign satLat = (hz.latencyD > LAT_W'(MAX_LAT)) ? LAT_W'(MAX_LAT) : hz.latencyD;

    assign rawStall = live && ((rsChk && busy[hz.rsD]) || (rtChk && busy[hz.rtD]));
    // Branches resolve in D, so even an ALU result still sitting in E is one cycle too late
    assign brStall  = live && hz.branchD &&
                      ((rsChk && lastValid && lastDest == hz.rsD) ||
                       (rtChk && lastValid && lastDest == hz.rtD));
    // A shorter-latency write must not land before an older, slower write to the same register
    assign wawStall = live && destOk && cnt[hz.writeRegisterD] > satLat;
    assign stall    = rawStall || brStall || wawStall;
    assign issue    = live && !stall;

    assign hz.Stall      = stall;
    assign hz.bubbleE    = stall;
    assign hz.issueD     = issue;
    assign hz.Flush      = issue && hz.branchD && (hz.takenBranchD ^ hz.predictionD);
    assign hz.CPCSignal  = hz.Flush || stall;
    assign hz.busyMask   = busy;
    assign hz.stallCount = stallCount;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lastValid  <= 1'b0;
            lastDest   <= '0;
            stallCount <= '0;
        end else begin
            lastValid  <= issue && destOk;
            lastDest   <= hz.writeRegisterD;
            stallCount <= (stall && stallCount != '1) ? stallCount + 1'b1 : stallCount;
        end
    end
endmodule

// File: tb/tb_scoreboard_hazard_unit.sv
// tb_scoreboard_hazard_unit: directed hazard scenarios plus random traffic against a scoreboard queue.
module tb_scoreboard_hazard_unit;
    import scoreboard_hazard_unit_pkg::*;

    typedef struct {
        bit v, k;
        int rs, rt;
        bit urs, urt, rw;
        int wr, lat;
        bit br, tk, pr;
    } insT;

    typedef struct packed {
        logic        stall, issue, flush, cpc;
        logic [31:0] busy;
        logic [31:0] cnt;
    } expT;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    scoreboard_hazard_unit_if hz ();
    scoreboard_hazard_unit dut (.clk(clk), .rst(rst), .hz(hz));

    int          mCnt [32];
    bit          mLastV;
    int          mLastD;
    int unsigned mStalls;
    expT         q [$];
    int          nChecks = 0;
    int          nBad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got !== exp) begin
            nBad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int minLat(int l);
        return l > MAX_LAT ? MAX_LAT : l;
    endfunction

    function automatic bit busyR(int r);
        return r != 0 && mCnt[r] > 0;
    endfunction

    function automatic insT op(int wr, int rs, int rt, int lat);
        insT i = '{v:1, k:0, rs:rs, rt:rt, urs:1, urt:1, rw:1, wr:wr, lat:lat, br:0, tk:0, pr:0};
        return i;
    endfunction

    function automatic insT nop();
        insT i = '{v:0, k:0, rs:0, rt:0, urs:0, urt:0, rw:0, wr:0, lat:0, br:0, tk:0, pr:0};
        return i;
    endfunction

    task automatic resetModel();
        foreach (mCnt[r]) mCnt[r] = 0;
        mLastV  = 0;
        mLastD  = 0;
        mStalls = 0;
    endtask

    // One D-stage cycle: drive, predict, compare at negedge, advance the model at posedge
    task automatic step(input insT i, output bit sOut, output bit iOut, output bit fOut, output bit cOut);
        expT e;
        bit  live, st, iss;
        hz.validD = i.v;  hz.killD = i.k;
        hz.rsD = REG_W'(i.rs);  hz.rtD = REG_W'(i.rt);
        hz.useRsD = i.urs;  hz.useRtD = i.urt;
        hz.regWriteD = i.rw;  hz.writeRegisterD = REG_W'(i.wr);
        hz.latencyD = LAT_W'(i.lat);
        hz.branchD = i.br;  hz.takenBranchD = i.tk;  hz.predictionD = i.pr;
        live = i.v && !i.k;
        st = live && ((i.urs && busyR(i.rs)) || (i.urt && busyR(i.rt)) ||
             (i.br && ((i.urs && i.rs != 0 && mLastV && mLastD == i.rs) ||
                       (i.urt && i.rt != 0 && mLastV && mLastD == i.rt))) ||
             (i.rw && i.wr != 0 && mCnt[i.wr] > minLat(i.lat)));
        iss = live && !st;
        e.stall = st;
        e.issue = iss;
        e.flush = iss && i.br && (i.tk != i.pr);
        e.cpc   = e.flush || st;
        for (int r = 0; r < 32; r++) e.busy[r] = busyR(r);
        e.cnt = mStalls;
        q.push_back(e);
        @(negedge clk);
        e = q.pop_front();
        check("Stall", hz.Stall, e.stall);
        check("bubbleE", hz.bubbleE, e.stall);
        check("issueD", hz.issueD, e.issue);
        check("Flush", hz.Flush, e.flush);
        check("CPCSignal", hz.CPCSignal, e.cpc);
        check("busyMask", hz.busyMask, e.busy);
        check("stallCount", hz.stallCount, e.cnt);
        sOut = hz.Stall;  iOut = hz.issueD;  fOut = hz.Flush;  cOut = hz.CPCSignal;
        @(posedge clk);
        for (int r = 1; r < 32; r++)
            if (iss && i.rw && i.wr == r) mCnt[r] = minLat(i.lat);
            else if (mCnt[r] > 0) mCnt[r]--;
        mLastV = iss && i.rw && i.wr != 0;
        mLastD = i.wr;
        if (st) mStalls++;
        #1;
    endtask

    task automatic issueWait(input insT i, output int n, output bit f, output bit c);
        bit s, iss;
        n = 0;
        iss = 0;
        for (int k = 0; k < 20 && !iss; k++) begin
            step(i, s, iss, f, c);
            if (s) n++;
        end
        check("issueWithinBudget", iss, 1'b1);
    endtask

    initial begin
        bit  s, iss, f, c;
        int  n;
        insT b;
        hz.validD = 0;  hz.killD = 0;  hz.rsD = '0;  hz.rtD = '0;
        hz.useRsD = 0;  hz.useRtD = 0;  hz.regWriteD = 0;  hz.writeRegisterD = '0;
        hz.latencyD = '0;  hz.branchD = 0;  hz.takenBranchD = 0;  hz.predictionD = 0;
        resetModel();
        #2;
        check("rstBusy", hz.busyMask, 32'h0);
        check("rstStall", hz.Stall, 1'b0);
        check("rstCount", hz.stallCount, 32'h0);
        #10 rst = 1'b1;
        @(posedge clk);
        #1;
        step(nop(), s, iss, f, c);

        step(op(8, 1, 2, LAT_LOAD), s, iss, f, c);
        issueWait(op(11, 8, 7, LAT_ALU), n, f, c);
        check("loadUseStalls", n, 1);
        check("loadUseCount", hz.stallCount, 32'd1);

        step(op(9, 1, 2, LAT_DIV), s, iss, f, c);
        issueWait(op(11, 9, 0, LAT_ALU), n, f, c);
        check("divDepStalls", n, 6);
        step(op(9, 1, 2, LAT_DIV), s, iss, f, c);
        issueWait(op(12, 10, 1, LAT_ALU), n, f, c);
        check("divIndepStalls", n, 0);

        step(op(3, 1, 2, LAT_ALU), s, iss, f, c);
        b = op(0, 3, 0, 0);
        b.rw = 0;  b.br = 1;  b.tk = 1;  b.pr = 0;
        issueWait(b, n, f, c);
        check("branchStalls", n, 1);
        check("branchFlush", f, 1'b1);
        check("branchCpc", c, 1'b1);

        step(op(4, 1, 2, 5), s, iss, f, c);
        issueWait(op(4, 1, 2, LAT_ALU), n, f, c);
        check("wawStalls", n, 5);
        step(op(4, 1, 2, 5), s, iss, f, c);
        b = op(4, 1, 2, LAT_ALU);
        b.k = 1;
        step(b, s, iss, f, c);
        check("killStall", s, 1'b0);
        check("killIssue", iss, 1'b0);

        step(op(0, 1, 2, 8), s, iss, f, c);
        step(nop(), s, iss, f, c);
        check("r0Busy", hz.busyMask[0], 1'b0);

        step(op(12, 1, 2, 15), s, iss, f, c);
        n = 0;
        for (int k = 0; k < 20 && hz.busyMask[12]; k++) begin
            n++;
            step(nop(), s, iss, f, c);
        end
        check("satBusyCycles", n, 8);

        step(op(5, 1, 2, 5), s, iss, f, c);
        step(nop(), s, iss, f, c);
        step(nop(), s, iss, f, c);
        check("preRstBusy5", hz.busyMask[5], 1'b1);
        #2 rst = 1'b0;
        #1;
        check("midRstBusy", hz.busyMask, 32'h0);
        check("midRstStall", hz.Stall, 1'b0);
        check("midRstCount", hz.stallCount, 32'h0);
        check("midRstFlush", hz.Flush, 1'b0);
        check("midRstCpc", hz.CPCSignal, 1'b0);
        resetModel();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        for (int k = 0; k < 300; k++) begin
            b.v   = $urandom_range(0, 9) < 8;
            b.k   = $urandom_range(0, 9) == 0;
            b.rs  = $urandom_range(0, 7);
            b.rt  = $urandom_range(0, 7);
            b.urs = $urandom_range(0, 1) == 1;
            b.urt = $urandom_range(0, 1) == 1;
            b.rw  = $urandom_range(0, 3) != 0;
            b.wr  = $urandom_range(0, 7);
            b.lat = $urandom_range(0, 15);
            b.br  = $urandom_range(0, 3) == 0;
            b.tk  = $urandom_range(0, 1) == 1;
            b.pr  = $urandom_range(0, 1) == 1;
            step(b, s, iss, f, c);
        end

        $display("test done: total=%0d bad=%0d", nChecks, nBad);
        $finish;
    end
endmodule
